arc4_param: RTL
===============

// Module: arc4_param
// PURPOSE
//  Parametrised ARC4 (RC4) stream decryptor, successor to the fixed 24-bit-key core. Key
//  length and keystream drop are compile-time parameters. Reads a length-prefixed ciphertext
//  from the CT RAM, writes the length-prefixed plaintext to the PT RAM, and holds the 256-byte
//  S-box internally. Sits between the key-search controller and the two on-chip message RAMs.
// PARAMETERS
//  KEY_BYTES  3  key length in bytes; legal range 1..32; key byte k = key[8*(KEY_BYTES-k)-1 -: 8]
//  DROP_N     0  keystream bytes generated and discarded before decryption (RC4-dropN); 0..1023
// PORTS
//  clk        in   1              system clock; all state changes on rising edge
//  rst_n      in   1              asynchronous active-low reset
//  en         in   1              start request; sampled only while rdy=1
//  rdy        out  1              1 = idle and able to accept en
//  key        in   8*KEY_BYTES    key; captured on the cycle en is accepted
//  ct_addr    out  8              CT RAM read address
//  ct_rddata  in   8              CT RAM data; valid the cycle after ct_addr is presented
//  pt_addr    out  8              PT RAM write address
//  pt_wrdata  out  8              PT RAM write data
//  pt_wren    out  1              PT RAM write strobe; one write per cycle in which it is high
// BEHAVIOUR
//  - Reset (async, any state): rdy=1, pt_wren=0, ct_addr=0, pt_addr=0, pt_wrdata=0, FSM=IDLE;
//    i, j, counters cleared. S-box contents need not be cleared (INIT rewrites them).
//  - Handshake: en=1 while rdy=1 at a rising edge -> key latched, rdy=0 from that edge.
//    en is ignored while rdy=0. rdy returns to 1 on the edge after the last PT write.
//  - FSM: IDLE -> INIT -> KSA -> DROP -> LEN -> PRGA -> IDLE.
//  - INIT: S[i]=i for i=0..255, one entry per cycle, exactly 256 cycles.
//  - KSA: j=0; for i=0..255: j=(j+S[i]+keybyte[i mod KEY_BYTES]) mod 256; swap S[i],S[j].
//    i mod KEY_BYTES computed with a wrapping counter, never a divider.
//  - DROP: i=j=0; run DROP_N PRGA steps with output discarded; skipped entirely if DROP_N=0.
//    i and j are NOT reset between DROP and PRGA.
//  - LEN: read ct[0]=L; write pt[0]=L (pt_wren one cycle).
//  - PRGA: for k=1..L: i=i+1; j=j+S[i]; swap S[i],S[j]; pad=S[(S[i]+S[j]) mod 256];
//    pt[k]=ct[k]^pad. Writes strictly in ascending address order, no PT address written twice.
//  - All index arithmetic is 8-bit, wrapping mod 256.
//  - L=0: only pt[0]=0 is written, then IDLE. L=255: pt_addr reaches 255 without wrapping to 0.
//  - Swap with i==j leaves S unchanged; no read-after-write hazard within a step.
//  - Latency bound, en accepted to rdy=1: <= 256 + 4*256 + 4*DROP_N + 5*(L+1) + 8 cycles.
//  - pt_wren is never high in IDLE, INIT, KSA or DROP. ct_addr reads never go past L.
// TESTING
//  1 Reset: hold rst_n=0 for 5 cycles -> rdy=1, pt_wren=0; release with en=0 for 10 cycles
//    -> rdy stays 1 and no PT writes occur.
//  2 KEY_BYTES=3, key=24'h4B6579 ("Key"), CT=09 BB F3 16 E8 D9 40 AF 0A D3
//    -> PT=09 50 6C 61 69 6E 74 65 78 74 ("Plaintext"); rdy=0 the cycle after en;
//    rdy=1 within the latency bound.
//  3 KEY_BYTES=4, key=32'h57696B69 ("Wiki"), CT=05 10 21 BF 04 20 -> PT=05 70 65 64 69 61 ("pedia").
//    KEY_BYTES=6, key="Secret", CT=0E 45 A0 1F 64 5F C3 5B 38 35 52 54 4B 9B F5
//    -> PT = 0E followed by "Attack at dawn".
//  4 L=0: CT[0]=00 -> exactly one write (pt[0]=00), rdy returns to 1; PT[1..255] untouched.
//  5 DROP_N=768, random key and L=255: PT must match the bench's behavioural RC4-drop768 model
//    byte for byte. PT[255] must be written and PT[0] must not be overwritten.
//  6 Abort and busy: pulse rst_n low mid-KSA -> rdy=1 and pt_wren=0 asynchronously; then
//    re-run test 2 -> same PT. en re-asserted while busy -> ignored, output unchanged.

Source files
------------

// File: rtl/arc4_param_if.sv
// arc4_param_if: bundle between the ARC4 decryptor, its key-search controller
// and the two message RAMs.
//   en/key    - start request and key from the controller
//   rdy       - decryptor idle and able to take en
//   ct_*      - CT RAM read port (ct_rddata valid the cycle after ct_addr)
//   pt_*      - PT RAM write port (one write per cycle with pt_wren high)
// KEY_BYTES must match the KEY_BYTES of the attached arc4_param.
interface arc4_param_if #(
  parameter int KEY_BYTES = 3
);
  logic                   en;
  logic                   rdy;
  logic [8*KEY_BYTES-1:0] key;
  logic [7:0]             ct_addr;
  logic [7:0]             ct_rddata;
  logic [7:0]             pt_addr;
  logic [7:0]             pt_wrdata;
  logic                   pt_wren;

  // Controller / RAM side.
  modport master (
    output en, key, ct_rddata,
    input  rdy, ct_addr, pt_addr, pt_wrdata, pt_wren
  );

  // Decryptor side.
  modport slave (
    input  en, key, ct_rddata,
    output rdy, ct_addr, pt_addr, pt_wrdata, pt_wren
  );
endinterface

// File: rtl/arc4_param.sv
// arc4_param: parametrised ARC4 (RC4-dropN) stream decryptor.
// Reads a length-prefixed ciphertext from the CT RAM and writes the
// length-prefixed plaintext to the PT RAM. The 256-byte S-box is held
// internally with one write per cycle, so a swap takes two cycles.
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - arc4_param_if.slave (en, rdy, key, ct_addr, ct_rddata,
//            pt_addr, pt_wrdata, pt_wren)
// Parameters:
//   KEY_BYTES - key length 1..32; key byte k = key[8*(KEY_BYTES-k)-1 -: 8]
//   DROP_N    - keystream bytes discarded before decryption, 0..1023
module arc4_param #(
  parameter int KEY_BYTES = 3,
  parameter int DROP_N    = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  arc4_param_if.slave  bus
);

  localparam logic [4:0] KIDX_LAST = 5'(KEY_BYTES - 1);
  localparam logic       DROP_EN   = (DROP_N != 0);
  localparam logic [9:0] DROP_LAST = (DROP_N == 0) ? 10'd0 : 10'(DROP_N - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_KSA  = 3'd2,
    ST_DROP = 3'd3,
    ST_LEN  = 3'd4,
    ST_PRGA = 3'd5,
    ST_DONE = 3'd6
  } state_e;

  state_e state_q, state_d;

  logic [7:0]             i_q, i_d;
  logic [7:0]             j_q, j_d;
  logic [1:0]             ph_q, ph_d;      // sub-step within a KSA/PRGA step
  logic [4:0]             kidx_q, kidx_d;  // i mod KEY_BYTES, wrapping counter
  logic [9:0]             drop_q, drop_d;
  logic [7:0]             si_q, si_d;      // S[i] captured before the swap
  logic [7:0]             sj_q, sj_d;      // S[j] captured before the swap
  logic [7:0]             len_q, len_d;
  logic [7:0]             k_q, k_d;        // current plaintext byte index
  logic [8*KEY_BYTES-1:0] key_q, key_d;
  logic                   rdy_q, rdy_d;
  logic [7:0]             ct_addr_q, ct_addr_d;
  logic [7:0]             pt_addr_q, pt_addr_d;
  logic [7:0]             pt_wrdata_q, pt_wrdata_d;
  logic                   pt_wren_q, pt_wren_d;

  logic [7:0] s_mem [256];
  logic       s_we_s;
  logic [7:0] s_waddr_s;
  logic [7:0] s_wdata_s;
  logic [7:0] key_byte_s;
  logic [7:0] i_inc_s;
  logic [7:0] pad_idx_s;

  assign i_inc_s   = i_q + 8'd1;
  // After the swap S[i]+S[j] equals the pre-swap S[j]+S[i].
  assign pad_idx_s = si_q + sj_q;

  // Key byte selected by the wrapping key index.
  always_comb begin
    key_byte_s = 8'h00;
    for (int b = 0; b < KEY_BYTES; b++) begin
      key_byte_s = key_byte_s |
                   ((kidx_q == 5'(b)) ? key_q[8*(KEY_BYTES-b)-1 -: 8] : 8'h00);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = bus.en ? ST_INIT : ST_IDLE;
      ST_INIT: state_d = (i_q == 8'hFF) ? ST_KSA : ST_INIT;
      ST_KSA: begin
        if (ph_q == 2'd2 && i_q == 8'hFF) begin
          state_d = DROP_EN ? ST_DROP : ST_LEN;
        end else begin
          state_d = ST_KSA;
        end
      end
      ST_DROP: state_d = (ph_q == 2'd2 && drop_q == DROP_LAST) ? ST_LEN : ST_DROP;
      ST_LEN:  state_d = (bus.ct_rddata == 8'd0) ? ST_DONE : ST_PRGA;
      ST_PRGA: state_d = (ph_q == 2'd3 && k_q == len_q) ? ST_DONE : ST_PRGA;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM output / datapath next-value logic.
  always_comb begin
    i_d         = i_q;
    j_d         = j_q;
    ph_d        = ph_q;
    kidx_d      = kidx_q;
    drop_d      = drop_q;
    si_d        = si_q;
    sj_d        = sj_q;
    len_d       = len_q;
    k_d         = k_q;
    key_d       = key_q;
    rdy_d       = rdy_q;
    ct_addr_d   = ct_addr_q;
    pt_addr_d   = pt_addr_q;
    pt_wrdata_d = pt_wrdata_q;
    pt_wren_d   = 1'b0;
    s_we_s      = 1'b0;
    s_waddr_s   = i_q;
    s_wdata_s   = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (bus.en) begin
          key_d     = bus.key;
          rdy_d     = 1'b0;
          ct_addr_d = 8'd0;
          i_d       = 8'd0;
          j_d       = 8'd0;
          ph_d      = 2'd0;
          kidx_d    = 5'd0;
          drop_d    = 10'd0;
        end else begin
          rdy_d = 1'b1;
        end
      end
      ST_INIT: begin
        s_we_s    = 1'b1;
        s_waddr_s = i_q;
        s_wdata_s = i_q;
        i_d       = i_inc_s;  // wraps to 0 ready for KSA
        j_d       = 8'd0;
        kidx_d    = 5'd0;
        ph_d      = 2'd0;
      end
      ST_KSA: begin
        case (ph_q)
          2'd0: begin
            si_d = s_mem[i_q];
            j_d  = j_q + s_mem[i_q] + key_byte_s;
            ph_d = 2'd1;
          end
          2'd1: begin
            s_we_s    = 1'b1;
            s_waddr_s = i_q;
            s_wdata_s = s_mem[j_q];
            ph_d      = 2'd2;
          end
          2'd2: begin
            s_we_s    = 1'b1;
            s_waddr_s = j_q;
            s_wdata_s = si_q;
            ph_d      = 2'd0;
            i_d       = i_inc_s;
            kidx_d    = (kidx_q == KIDX_LAST) ? 5'd0 : kidx_q + 5'd1;
            // Last step: i wraps to 0 and j restarts for the keystream.
            j_d       = (i_q == 8'hFF) ? 8'd0 : j_q;
          end
          default: ph_d = 2'd0;
        endcase
      end
      ST_DROP, ST_PRGA: begin
        case (ph_q)
          2'd0: begin
            i_d  = i_inc_s;
            si_d = s_mem[i_inc_s];
            j_d  = j_q + s_mem[i_inc_s];
            ph_d = 2'd1;
          end
          2'd1: begin
            sj_d      = s_mem[j_q];
            s_we_s    = 1'b1;
            s_waddr_s = i_q;
            s_wdata_s = s_mem[j_q];
            ph_d      = 2'd2;
          end
          2'd2: begin
            s_we_s    = 1'b1;
            s_waddr_s = j_q;
            s_wdata_s = si_q;
            if (state_q == ST_DROP) begin
              ph_d   = 2'd0;
              drop_d = drop_q + 10'd1;
            end else begin
              ph_d   = 2'd3;
            end
          end
          2'd3: begin
            pt_wren_d   = 1'b1;
            pt_addr_d   = k_q;
            pt_wrdata_d = bus.ct_rddata ^ s_mem[pad_idx_s];
            ph_d        = 2'd0;
            // Hold the last address so reads never pass L and k never wraps.
            if (k_q == len_q) begin
              k_d       = k_q;
              ct_addr_d = ct_addr_q;
            end else begin
              k_d       = k_q + 8'd1;
              ct_addr_d = k_q + 8'd1;
            end
          end
          default: ph_d = 2'd0;
        endcase
      end
      ST_LEN: begin
        len_d       = bus.ct_rddata;
        pt_wren_d   = 1'b1;
        pt_addr_d   = 8'd0;
        pt_wrdata_d = bus.ct_rddata;
        k_d         = 8'd1;
        ph_d        = 2'd0;
        ct_addr_d   = (bus.ct_rddata == 8'd0) ? 8'd0 : 8'd1;
      end
      ST_DONE: rdy_d = 1'b1;  // the final PT write commits on this edge
      default: rdy_d = 1'b1;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q         <= 8'd0;
      j_q         <= 8'd0;
      ph_q        <= 2'd0;
      kidx_q      <= 5'd0;
      drop_q      <= 10'd0;
      si_q        <= 8'd0;
      sj_q        <= 8'd0;
      len_q       <= 8'd0;
      k_q         <= 8'd0;
      key_q       <= '0;
      rdy_q       <= 1'b1;
      ct_addr_q   <= 8'd0;
      pt_addr_q   <= 8'd0;
      pt_wrdata_q <= 8'd0;
      pt_wren_q   <= 1'b0;
    end else begin
      i_q         <= i_d;
      j_q         <= j_d;
      ph_q        <= ph_d;
      kidx_q      <= kidx_d;
      drop_q      <= drop_d;
      si_q        <= si_d;
      sj_q        <= sj_d;
      len_q       <= len_d;
      k_q         <= k_d;
      key_q       <= key_d;
      rdy_q       <= rdy_d;
      ct_addr_q   <= ct_addr_d;
      pt_addr_q   <= pt_addr_d;
      pt_wrdata_q <= pt_wrdata_d;
      pt_wren_q   <= pt_wren_d;
    end
  end

  // S-box storage; contents are rewritten by INIT so no reset is needed.
  always_ff @(posedge clk) begin
    if (s_we_s) begin
      s_mem[s_waddr_s] <= s_wdata_s;
    end
  end

  assign bus.rdy       = rdy_q;
  assign bus.ct_addr   = ct_addr_q;
  assign bus.pt_addr   = pt_addr_q;
  assign bus.pt_wrdata = pt_wrdata_q;
  assign bus.pt_wren   = pt_wren_q;

endmodule
